cmp_bist_driver: RTL and testbench

- Built-in self-test initiator for the team's WIDTH-bit magnitude comparator (operands a, b, enable; outputs eq, greater, lesser).
- Sweeps every operand pair, waits a programmable settle time, samples the three flags and checks them against a golden result. Optionally runs one disabled-enable check.
- Reports pass/fail, a saturating error count and the first failing pair.
- Sits beside the comparator in the ALU test wrapper and drives the comparator inputs in place of the datapath during self-test.

---
 rtl/cmp_bist_driver.sv | 158 +++++++++++++++
 tb/tb_cmp_bist_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_bist_driver.sv
// Self-test initiator for the WIDTH-bit magnitude comparator: sweeps all operand pairs,
// checks eq/gt/lt against a golden result and records the error count and first failing pair.
module cmp_bist_driver #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE        = 1,
  parameter int unsigned CHECK_DISABLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   cmp_a,
  output logic [WIDTH-1:0]   cmp_b,
  output logic               cmp_en,
  input  logic               cmp_eq,
  input  logic               cmp_gt,
  input  logic               cmp_lt,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WaitLast = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [EW-1:0] ErrMax = '1;

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              en_q, en_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [EW-1:0]     err_q, err_d, err_now;
  logic              fv_q, fv_d;
  logic [WIDTH-1:0]  fa_q, fa_d, fb_q, fb_d;
  logic [2:0]        golden;
  logic              mismatch;
  logic              last_pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  // Flags ordered {eq, gt, lt}; a disabled comparator must hold all three low.
  assign golden    = en_q ? {a_q == b_q, a_q > b_q, a_q < b_q} : 3'b000;
  assign mismatch  = ({cmp_eq, cmp_gt, cmp_lt} != golden);
  assign last_pair = (&a_q) && (&b_q);
  assign err_now   = !mismatch ? err_q : ((err_q == ErrMax) ? err_q : err_q + 1'b1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = '0;
          b_d     = '0;
          en_d    = 1'b1;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? StWait : StCheck;
      end
      StWait: begin
        if (cnt_q == WaitLast) state_d = StCheck;
        else cnt_d = cnt_q + 1'b1;
      end
      StCheck: begin
        err_d = err_now;
        if (mismatch && !fv_q) begin
          fv_d = 1'b1;
          fa_d = a_q;
          fb_d = b_q;
        end
        // The disable vector (en=0) is always the last one when present.
        if (!en_q || (last_pair && (CHECK_DISABLE == 0))) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_now == '0);
          state_d = StDone;
        end else if (last_pair) begin
          a_d     = '0;
          b_d     = '0;
          en_d    = 1'b0;
          state_d = StDrive;
        end else begin
          b_d = b_q + 1'b1;
          if (&b_q) a_d = a_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmp_a      = a_q;
  assign cmp_b      = b_q;
  assign cmp_en     = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

endmodule

// File: tb/tb_cmp_bist_driver.sv
// Bench for cmp_bist_driver: drives it with a configurable (possibly faulty) comparator model
// and checks run length, pass/fail, error count and first failing pair.
module tb_cmp_bist_driver;

  localparam int W = 4;
  localparam int RUN_LEN = 771;

  logic         clk, rst, start;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_en, cmp_eq, cmp_gt, cmp_lt;
  logic         busy, done, pass;
  logic [2*W:0] err_count;
  logic         fail_valid;
  logic [W-1:0] fail_a, fail_b;

  int errs = 0;
  int checks = 0;

  int         mode;
  logic [2:0] fault_tab [256];
  logic [2:0] fault_dis;
  logic [2:0] flags;

  cmp_bist_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_en(cmp_en),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: 0 ideal, 1 gt stuck 0, 2 gt/lt swapped, 3 ignores enable,
  // 4 eq+gt at (5,5), 5 random XOR faults from fault_tab/fault_dis.
  always_comb begin
    logic [2:0] id;
    id = {cmp_a == cmp_b, cmp_a > cmp_b, cmp_a < cmp_b};
    flags = cmp_en ? id : 3'b000;
    case (mode)
      1: flags[1] = 1'b0;
      2: flags = {flags[2], flags[0], flags[1]};
      3: flags = id;
      4: if (cmp_en && cmp_a == 4'd5 && cmp_b == 4'd5) flags[1] = 1'b1;
      5: flags = flags ^ (cmp_en ? fault_tab[{cmp_a, cmp_b}] : fault_dis);
      default: ;
    endcase
  end
  assign cmp_eq = flags[2];
  assign cmp_gt = flags[1];
  assign cmp_lt = flags[0];

  // Pulses start, optionally pulses it again at cycle extra_at, and counts cycles to done.
  task automatic run_to_done(input int extra_at, output int cycles, output bit busy_bad);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    busy_bad = 1'b0;
    while (!done && cycles < 2000) begin
      if (!busy) busy_bad = 1'b1;
      start = (cycles == extra_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmp_a, cmp_b, cmp_en, busy, done, pass, err_count, fail_valid, fail_a, fail_b} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got a=%0d b=%0d en=%b busy=%b done=%b pass=%b err=%0d fv=%b fa=%0d fb=%0d, want all 0",
               cmp_a, cmp_b, cmp_en, busy, done, pass, err_count, fail_valid, fail_a, fail_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_ideal();
    int cyc; bit bb;
    mode = 0;
    run_to_done(-1, cyc, bb);
    checks++;
    if (cyc !== RUN_LEN) begin errs++; $display("FAIL ideal_len: got %0d want %0d", cyc, RUN_LEN); end
    checks++;
    if (bb !== 1'b0) begin errs++; $display("FAIL ideal_busy: busy dropped early, want busy=1 throughout"); end
    checks++;
    if ({done, pass, err_count, fail_valid, busy, cmp_en} !== {1'b1, 1'b1, 9'd0, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL ideal_result: done=%b pass=%b err=%0d fv=%b busy=%b en=%b, want 1 1 0 0 0 0",
               done, pass, err_count, fail_valid, busy, cmp_en);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errs++; $display("FAIL done_hold: done=%b pass=%b want 1 1", done, pass);
    end
  endtask

  // Fixed-fault scenario against the expected result derived from the fault itself.
  task automatic test_fault(input string name, input int m, input int exp_err,
                            input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
    int cyc; bit bb;
    mode = m;
    run_to_done(-1, cyc, bb);
    checks++;
    if (cyc !== RUN_LEN) begin errs++; $display("FAIL %s_len: got %0d want %0d", name, cyc, RUN_LEN); end
    checks++;
    if (err_count !== 9'(exp_err) || pass !== 1'b0) begin
      errs++; $display("FAIL %s_count: err=%0d pass=%b, want err=%0d pass=0", name, err_count, pass, exp_err);
    end
    checks++;
    if (fail_valid !== 1'b1 || fail_a !== exp_a || fail_b !== exp_b) begin
      errs++;
      $display("FAIL %s_first: fv=%b a=%0d b=%0d, want fv=1 a=%0d b=%0d", name, fail_valid, fail_a, fail_b,
               exp_a, exp_b);
    end
  endtask

  task automatic test_random_faults();
    int cyc; bit bb;
    int exp_err; bit exp_fv; logic [W-1:0] exp_a, exp_b;
    logic [2:0] gold, got;
    mode = 5;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 256; i++)
        fault_tab[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      fault_dis = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      exp_err = 0; exp_fv = 0; exp_a = '0; exp_b = '0;
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          gold = {a == b, a > b, a < b};
          got = gold ^ fault_tab[a * 16 + b];
          if (got != gold) begin
            exp_err++;
            if (!exp_fv) begin exp_fv = 1; exp_a = W'(a); exp_b = W'(b); end
          end
        end
      end
      if (fault_dis != 3'd0) begin
        exp_err++;
        if (!exp_fv) begin exp_fv = 1; exp_a = '0; exp_b = '0; end
      end
      run_to_done(-1, cyc, bb);
      checks++;
      if (cyc !== RUN_LEN) begin errs++; $display("FAIL rand%0d_len: got %0d want %0d", it, cyc, RUN_LEN); end
      checks++;
      if (err_count !== 9'(exp_err) || pass !== (exp_err == 0)) begin
        errs++; $display("FAIL rand%0d_count: err=%0d pass=%b, want err=%0d pass=%b", it, err_count, pass,
                         exp_err, exp_err == 0);
      end
      checks++;
      if (fail_valid !== exp_fv || (exp_fv && (fail_a !== exp_a || fail_b !== exp_b))) begin
        errs++; $display("FAIL rand%0d_first: fv=%b a=%0d b=%0d, want fv=%b a=%0d b=%0d", it, fail_valid,
                         fail_a, fail_b, exp_fv, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc; bit bb;
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmp_a, cmp_b, cmp_en, busy, done, pass, err_count, fail_valid, fail_a, fail_b} !== '0) begin
      errs++;
      $display("FAIL midrun_reset: got a=%0d b=%0d en=%b busy=%b done=%b err=%0d fv=%b, want all 0",
               cmp_a, cmp_b, cmp_en, busy, done, err_count, fail_valid);
    end
    @(negedge clk); rst = 1'b0;
    mode = 0;
    run_to_done(50, cyc, bb);
    checks++;
    if (cyc !== RUN_LEN || bb !== 1'b0) begin
      errs++; $display("FAIL ignored_start: len=%0d busy_dropped=%b, want %0d 0", cyc, bb, RUN_LEN);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 9'd0 || fail_valid !== 1'b0) begin
      errs++; $display("FAIL rerun_clean: pass=%b err=%0d fv=%b, want 1 0 0", pass, err_count, fail_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fault_tab[i] = 3'd0;
    fault_dis = 3'd0;
    test_reset();
    test_ideal();
    test_fault("gt_stuck0", 1, 120, 4'd1, 4'd0);
    test_fault("gt_lt_swap", 2, 240, 4'd0, 4'd1);
    test_fault("ignore_en", 3, 1, 4'd0, 4'd0);
    test_fault("multi_hot", 4, 1, 4'd5, 4'd5);
    test_ideal();
    test_random_faults();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
